// File: rtl/lelo_temp_pkg.sv
// Shared types and constants for the ring-oscillator temperature readout.
package lelo_temp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StGate,
    StDone
  } state_e;

  localparam int unsigned GateLenW = 15;

  localparam logic [GateLenW-1:0] GateLen0 = 15'd256;
  localparam logic [GateLenW-1:0] GateLen1 = 15'd1024;
  localparam logic [GateLenW-1:0] GateLen2 = 15'd4096;
  localparam logic [GateLenW-1:0] GateLen3 = 15'd16384;

  // Map the 2-bit gate select onto a gate length in clk cycles.
  function automatic logic [GateLenW-1:0] gate_len(input logic [1:0] sel);
    logic [GateLenW-1:0] len;
    case (sel)
      2'd0:    len = GateLen0;
      2'd1:    len = GateLen1;
      2'd2:    len = GateLen2;
      default: len = GateLen3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/lelo_sync_edge.sv
// Synchronizes the asynchronous oscillator input and emits a one-cycle pulse per rising edge.
module lelo_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  // Shift the raw input through the synchronizer; history holds the previous synced value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], osc_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/lelo_temp_readout.sv
// Counts ring-oscillator edges over a selectable gate window and reports the count.
module lelo_temp_readout
  import lelo_temp_pkg::*;
#(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       gate_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             ovf
);

  state_e              state_q, state_d;
  logic [GateLenW-1:0] glen_q, glen_d;
  logic [GateLenW-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0]    ecnt_q, ecnt_d;
  logic                oint_q, oint_d;
  logic [CNT_W-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                rise;

  lelo_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .osc_i (osc_in),
    .rise_o(rise)
  );

  // Next-state, counter and output logic for the measurement sequence.
  always_comb begin
    state_d  = state_q;
    glen_d   = glen_q;
    gcnt_d   = gcnt_q;
    ecnt_d   = ecnt_q;
    oint_d   = oint_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          glen_d  = gate_len(gate_sel);
          state_d = StArm;
        end
      end
      StArm: begin
        busy    = 1'b1;
        gcnt_d  = '0;
        ecnt_d  = '0;
        oint_d  = 1'b0;
        state_d = abort ? StIdle : StGate;
      end
      StGate: begin
        busy   = 1'b1;
        gcnt_d = gcnt_q + GateLenW'(1);
        // Saturate rather than wrap; a lost edge is remembered as overflow.
        if (rise) begin
          if (ecnt_q == {CNT_W{1'b1}}) begin
            oint_d = 1'b1;
          end else begin
            ecnt_d = ecnt_q + CNT_W'(1);
          end
        end
        if (abort) begin
          state_d = StIdle;
        end else if (gcnt_q == glen_q - GateLenW'(1)) begin
          // Load including this cycle's edge so result is valid alongside done.
          state_d  = StDone;
          result_d = ecnt_d;
          ovf_d    = oint_d;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      glen_q   <= '0;
      gcnt_q   <= '0;
      ecnt_q   <= '0;
      oint_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      glen_q   <= glen_d;
      gcnt_q   <= gcnt_d;
      ecnt_q   <= ecnt_d;
      oint_q   <= oint_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_lelo_temp_readout.sv
// Self-checking bench for lelo_temp_readout: directed table, random runs against a model,
// and hand-written abort, back-to-back and reset sequences.
module tb_lelo_temp_readout;

  localparam int CNT_W = 12;
  localparam int SYNC  = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             osc_in = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       gate_sel = 2'd0;
  logic             busy, done, ovf;
  logic [CNT_W-1:0] result;

  lelo_temp_readout #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .osc_in  (osc_in),
    .start   (start),
    .abort   (abort),
    .gate_sel(gate_sel),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;       // 0 const0, 1 const1, 2 clk/8, 3 clk/2, other random
  bit osc_arr[0:65535]; // osc_in value seen at the posedge with that index

  typedef struct {
    int g;
    int m;
    bit idle_abort;
    int lat;
    int res;
    bit ov;
  } vec_t;

  vec_t vecs[5];

  function automatic int gate_n(input int g);
    return 256 << (2 * g);
  endfunction

  function automatic bit gen(input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 8) < 4;
      3:       return (k % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Rising transitions the synchronized stream shows during the N gate cycles after
  // the posedge p that accepted start.
  function automatic int model_cnt(input int p, input int n);
    int c = 0;
    for (int k = p + 2 - SYNC; k <= p + n + 1 - SYNC; k++) begin
      if (osc_arr[k] && !osc_arr[k-1]) c++;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    osc_in = gen(cyc + 1);
    if (cyc + 1 < 65536) osc_arr[cyc+1] = osc_in;
  endtask

  task automatic run_meas(input string tag, input int g, input int m, input bit idle_abort,
                          output int lat, output int p, output logic [CNT_W-1:0] res,
                          output logic ov);
    int t0;
    bit found;
    mode = m;
    repeat (4) tick();
    gate_sel = 2'(g);
    start = 1'b1;
    abort = idle_abort;
    t0 = cyc;
    tick();
    start = 1'b0;
    abort = 1'b0;
    gate_sel = 2'($urandom_range(0, 3));
    check({tag, "_busy_arm"}, 32'(busy), 32'd1);
    found = 1'b0;
    for (int i = 0; i < gate_n(g) + 20; i++) begin
      tick();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    lat = cyc - t0;
    p = t0 + 1;
    res = result;
    ov = ovf;
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat, p, ndone, t0, dprev, cnt, g, exp_c;
    logic [CNT_W-1:0] res, prev_res;
    logic ov;
    bit found;

    vecs[0] = '{g: 0, m: 2, idle_abort: 0, lat: 258,   res: 32,   ov: 0};
    vecs[1] = '{g: 3, m: 3, idle_abort: 0, lat: 16386, res: 4095, ov: 1};
    vecs[2] = '{g: 2, m: 0, idle_abort: 0, lat: 4098,  res: 0,    ov: 0};
    vecs[3] = '{g: 0, m: 1, idle_abort: 1, lat: 258,   res: 0,    ov: 0};
    vecs[4] = '{g: 1, m: 2, idle_abort: 0, lat: 1026,  res: 128,  ov: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_meas($sformatf("vec%0d", i), vecs[i].g, vecs[i].m, vecs[i].idle_abort,
               lat, p, res, ov);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ov));
    end

    // Random oscillator streams against the model; the last run sits near saturation
    for (int r = 0; r < 6; r++) begin
      g = (r == 5) ? 3 : int'($urandom_range(0, 1));
      run_meas($sformatf("rnd%0d", r), g, 4, 1'b0, lat, p, res, ov);
      exp_c = model_cnt(p, gate_n(g));
      check($sformatf("rnd%0d_latency", r), 32'(lat), 32'(gate_n(g) + 2));
      check($sformatf("rnd%0d_result", r), 32'(res), 32'((exp_c > MAXC) ? MAXC : exp_c));
      check($sformatf("rnd%0d_ovf", r), 32'(ov), 32'(exp_c > MAXC));
    end

    // Abort 100 cycles into GATE
    prev_res = result;
    mode = 4;
    gate_sel = 2'd1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc < t0 + 102) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    count_dones(1100, ndone);
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_result_kept", 32'(result), 32'(prev_res));

    // Abort coinciding with the last GATE cycle wins over completion
    mode = 2;
    gate_sel = 2'd0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc < t0 + 257) tick();
    check("abort_last_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_last_busy_after", 32'(busy), 32'd0);
    count_dones(20, ndone);
    check("abort_last_no_done", 32'(ndone), 32'd0);
    check("abort_last_result_kept", 32'(result), 32'(prev_res));

    // Back-to-back with start held high
    mode = 4;
    gate_sel = 2'd1;
    start = 1'b1;
    t0 = cyc;
    p = t0 + 1;
    dprev = 0;
    for (int r = 0; r < 3; r++) begin
      found = 1'b0;
      for (int i = 0; i < 1100; i++) begin
        tick();
        if (done) begin
          found = 1'b1;
          break;
        end
      end
      check($sformatf("b2b%0d_done_seen", r), 32'(found), 32'd1);
      if (r == 0) check("b2b0_latency", 32'(cyc - t0), 32'd1026);
      else check($sformatf("b2b%0d_period", r), 32'(cyc - dprev), 32'd1027);
      cnt = model_cnt(p, 1024);
      check($sformatf("b2b%0d_result", r), 32'(result), 32'((cnt > MAXC) ? MAXC : cnt));
      check($sformatf("b2b%0d_busy_done", r), 32'(busy), 32'd0);
      dprev = cyc;
      p = cyc + 2;
      if (r == 2) start = 1'b0;
      tick();
      check($sformatf("b2b%0d_busy_idle", r), 32'(busy), 32'd0);
      tick();
      check($sformatf("b2b%0d_busy_next", r), 32'(busy), 32'(r != 2));
    end

    // Asynchronous reset in the middle of GATE
    mode = 3;
    repeat (5) tick();
    gate_sel = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (200) tick();
    check("rstmid_busy_before", 32'(busy), 32'd1);
    check("rstmid_result_nonzero", 32'(result != '0), 32'd1);
    rst_n = 1'b0;
    #2;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_result", 32'(result), 32'd0);
    check("rstmid_ovf", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    count_dones(1100, ndone);
    check("rstmid_no_done", 32'(ndone), 32'd0);
    check("rstmid_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
